// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment codes are active low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int NUM_BITS   = 9;
    localparam int NUM_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Double-dabble correction: a nibble of 5 or more would exceed 9 after doubling.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seg7_scan_controller_if.sv
// Value handshake between the application logic and the scan controller.
interface seg7_scan_controller_if;
    import seg7_pkg::*;

    logic [NUM_BITS-1:0] value_in;
    logic                value_valid;
    logic                value_ready;
    logic                busy;

    modport master (
        output value_in,
        output value_valid,
        input  value_ready,
        input  busy
    );

    modport slave (
        input  value_in,
        input  value_valid,
        output value_ready,
        output busy
    );

endinterface

// File: rtl/seg7_digit_decoder.sv
// BCD digit to active-low seven-segment pattern, with a forced-blank input.
module seg7_digit_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg_n = SEG_0;
                4'd1:    seg_n = SEG_1;
                4'd2:    seg_n = SEG_2;
                4'd3:    seg_n = SEG_3;
                4'd4:    seg_n = SEG_4;
                4'd5:    seg_n = SEG_5;
                4'd6:    seg_n = SEG_6;
                4'd7:    seg_n = SEG_7;
                4'd8:    seg_n = SEG_8;
                4'd9:    seg_n = SEG_9;
                default: seg_n = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Binary-to-BCD conversion (one bit per clock) feeding a continuously
// multiplexed 3-digit, active-low seven-segment display.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV   = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    seg7_scan_controller_if.slave  bus,
    output logic [6:0]             seg_n,
    output logic [3:0]             an_n
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    state_t              state, state_next;
    logic                ready, busy_int, accept, load_en;
    logic [NUM_BITS-1:0] shift_reg;
    logic [11:0]         acc;
    logic [10:0]         acc_adj;
    logic [3:0]          hund_adj;
    logic                unused_hund_msb;
    logic [3:0]          bit_cnt;
    logic [3:0]          shown_h, shown_t, shown_o;
    logic [3:0]          next_h, next_t, next_o;

    logic [CNT_W-1:0]    refresh_cnt;
    logic                cnt_wrap;
    logic [1:0]          scan_idx, idx_next;
    logic [3:0]          digit_sel;
    logic                blank_sel, blank_h, blank_t;
    logic [3:0]          an_next;
    logic [6:0]          seg_next;

    // ---- control FSM ----
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy_int   = 1'b0;
        accept     = 1'b0;
        load_en    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.value_valid) begin
                    accept     = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                busy_int = 1'b1;
                if (bit_cnt == 4'(NUM_BITS - 1)) state_next = LOAD;
            end
            LOAD: begin
                load_en    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.value_ready = ready;
    assign bus.busy        = busy_int;

    // ---- shift-add-3 engine ----
    // Adjust happens before each shift, so the last shift leaves acc unadjusted.
    // The hundreds nibble stays <= 2 before adjust, so its top bit is always dropped.
    assign hund_adj        = add3(acc[11:8]);
    assign unused_hund_msb = hund_adj[3];
    assign acc_adj         = {hund_adj[2:0], add3(acc[7:4]), add3(acc[3:0])};

    always_ff @(posedge clk) begin
        if (accept) begin
            shift_reg <= bus.value_in;
            acc       <= '0;
        end else if (state == CONV) begin
            acc       <= {acc_adj, shift_reg[NUM_BITS-1]};
            shift_reg <= {shift_reg[NUM_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                 bit_cnt <= '0;
        else if (accept)         bit_cnt <= '0;
        else if (state == CONV)  bit_cnt <= bit_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shown_h <= '0;
            shown_t <= '0;
            shown_o <= '0;
        end else if (load_en) begin
            shown_h <= acc[11:8];
            shown_t <= acc[7:4];
            shown_o <= acc[3:0];
        end
    end

    // ---- scan / output register stage ----
    // Outputs are built from next-cycle digits so a LOAD is visible on the same edge.
    assign next_h = load_en ? acc[11:8] : shown_h;
    assign next_t = load_en ? acc[7:4]  : shown_t;
    assign next_o = load_en ? acc[3:0]  : shown_o;

    assign blank_h  = BLANK_LEADING && (next_h == 4'd0);
    assign blank_t  = BLANK_LEADING && (next_h == 4'd0) && (next_t == 4'd0);
    assign cnt_wrap = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        idx_next = scan_idx;
        if (cnt_wrap) idx_next = (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
    end

    always_comb begin
        digit_sel = next_o;
        blank_sel = 1'b0;
        an_next   = 4'b1110;
        case (idx_next)
            2'd1: begin
                digit_sel = next_t;
                blank_sel = blank_t;
                an_next   = 4'b1101;
            end
            2'd2: begin
                digit_sel = next_h;
                blank_sel = blank_h;
                an_next   = 4'b1011;
            end
            default: ;
        endcase
    end

    seg7_digit_decoder u_decoder (
        .digit (digit_sel),
        .blank (blank_sel),
        .seg_n (seg_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            scan_idx    <= 2'd0;
            an_n        <= 4'b1110;
            seg_n       <= SEG_0;
        end else begin
            refresh_cnt <= cnt_wrap ? '0 : refresh_cnt + 1'b1;
            scan_idx    <= idx_next;
            an_n        <= an_next;
            seg_n       <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller: expected digit patterns are queued
// when a value is accepted and compared once the display has been scanned.
module tb_seg7_scan_controller;

    localparam int RD = 4;

    typedef struct packed {
        logic [6:0] h;
        logic [6:0] t;
        logic [6:0] o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_n, seg_n_nb;
    logic [3:0] an_n, an_n_nb;
    int         tests = 0;
    int         fails = 0;
    exp_t       sb[$];

    seg7_scan_controller_if bus();
    seg7_scan_controller_if bus_nb();

    seg7_scan_controller #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b1)) dut (
        .clk (clk), .rst (rst), .bus (bus), .seg_n (seg_n), .an_n (an_n)
    );

    seg7_scan_controller #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b0)) dut_nb (
        .clk (clk), .rst (rst), .bus (bus_nb), .seg_n (seg_n_nb), .an_n (an_n_nb)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic exp_t model(input int v, input bit blank_lead);
        exp_t e;
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        e.h = (blank_lead && h == 0) ? 7'b1111111 : seg_code(h);
        e.t = (blank_lead && h == 0 && t == 0) ? 7'b1111111 : seg_code(t);
        e.o = seg_code(o);
        return e;
    endfunction

    task automatic accept(input bit nb, input int v, input bit push);
        bit done;
        done = 1'b0;
        if (nb) begin bus_nb.value_in = 9'(v); bus_nb.value_valid = 1'b1; end
        else    begin bus.value_in    = 9'(v); bus.value_valid    = 1'b1; end
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if ((nb ? bus_nb.value_ready : bus.value_ready) === 1'b1) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        bus.value_valid    = 1'b0;
        bus_nb.value_valid = 1'b0;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL accept_%0d: value_ready never seen high, required 1", v);
        end else if (push) begin
            sb.push_back(model(v, !nb));
        end
    endtask

    task automatic wait_ready(input bit nb);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if ((nb ? bus_nb.value_ready : bus.value_ready) === 1'b1) done = 1'b1;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL wait_ready: value_ready stuck low, required 1 within 30 cycles");
        end
    endtask

    task automatic check_display(input string name, input bit nb);
        exp_t got, exp;
        bit [2:0] seen;
        logic [3:0] a;
        logic [6:0] s;
        seen = 3'b000;
        got  = '1;
        for (int i = 0; i < 3 * RD + 1; i++) begin
            @(negedge clk);
            a = nb ? an_n_nb : an_n;
            s = nb ? seg_n_nb : seg_n;
            case (a)
                4'b1110: begin got.o = s; seen[0] = 1'b1; end
                4'b1101: begin got.t = s; seen[1] = 1'b1; end
                4'b1011: begin got.h = s; seen[2] = 1'b1; end
                default: begin
                    tests++;
                    fails++;
                    $display("FAIL %s_an_n: got %b, required one of 1110/1101/1011", name, a);
                end
            endcase
        end
        tests++;
        if (seen !== 3'b111) begin
            fails++;
            $display("FAIL %s_scan: slots seen %b, required 111", name, seen);
        end
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s_scoreboard: queue empty, required an entry", name);
        end else begin
            exp = sb.pop_front();
            tests++;
            if (got.h !== exp.h) begin
                fails++;
                $display("FAIL %s_hundreds: got %b, required %b", name, got.h, exp.h);
            end
            tests++;
            if (got.t !== exp.t) begin
                fails++;
                $display("FAIL %s_tens: got %b, required %b", name, got.t, exp.t);
            end
            tests++;
            if (got.o !== exp.o) begin
                fails++;
                $display("FAIL %s_ones: got %b, required %b", name, got.o, exp.o);
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        rst = 1'b1;
        bus.value_valid = 1'b0;    bus.value_in = '0;
        bus_nb.value_valid = 1'b0; bus_nb.value_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (an_n !== 4'b1110 || seg_n !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_display: an_n=%b seg_n=%b, required 1110/1000000", an_n, seg_n);
        end
        tests++;
        if (bus.value_ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake: ready=%b busy=%b, required 1/0", bus.value_ready, bus.busy);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 6 * RD; k++) begin
            @(negedge clk);
            case ((k / RD) % 3)
                0:       begin exp_an = 4'b1110; exp_seg = 7'b1000000; end
                1:       begin exp_an = 4'b1101; exp_seg = 7'b1111111; end
                default: begin exp_an = 4'b1011; exp_seg = 7'b1111111; end
            endcase
            tests++;
            if (an_n !== exp_an || seg_n !== exp_seg) begin
                fails++;
                $display("FAIL scan_k%0d: an_n=%b seg_n=%b, required %b/%b", k, an_n, seg_n, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_latency_255();
        int busy_cycles;
        logic [6:0] exp_seg;
        busy_cycles = 0;
        accept(1'b0, 255, 1'b1);
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cycles++;
            if (j == 10) begin
                tests++;
                if (bus.value_ready !== 1'b0 || bus.busy !== 1'b0) begin
                    fails++;
                    $display("FAIL load_cycle: ready=%b busy=%b, required 0/0", bus.value_ready, bus.busy);
                end
            end
            if (j == 11) begin
                tests++;
                if (bus.value_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL ready_c11: got %b, required 1", bus.value_ready);
                end
                exp_seg = (an_n == 4'b1110) ? 7'b0010010 :
                          (an_n == 4'b1101) ? 7'b0010010 : 7'b0100100;
                tests++;
                if (seg_n !== exp_seg) begin
                    fails++;
                    $display("FAIL visible_c11: an_n=%b seg_n=%b, required %b", an_n, seg_n, exp_seg);
                end
            end
        end
        tests++;
        if (busy_cycles != 9) begin
            fails++;
            $display("FAIL busy_len: got %0d cycles, required 9", busy_cycles);
        end
        check_display("v255", 1'b0);
    endtask

    task automatic test_range();
        accept(1'b0, 511, 1'b1);
        wait_ready(1'b0);
        check_display("v511", 1'b0);
        accept(1'b0, 0, 1'b1);
        wait_ready(1'b0);
        check_display("v0", 1'b0);
        accept(1'b1, 0, 1'b1);
        wait_ready(1'b1);
        check_display("v0_noblank", 1'b1);
    endtask

    task automatic test_back_to_back();
        bit hit;
        accept(1'b0, 7, 1'b1);
        bus.value_in = 9'd300;
        bus.value_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.value_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.value_ready !== 1'b1) hit = 1'b1;
        end
        tests++;
        if (hit) begin
            fails++;
            $display("FAIL ignore_300: busy/ready changed after drop, required busy=0 ready=1");
        end
        check_display("v7", 1'b0);
        accept(1'b0, 7, 1'b0);
        bus.value_in = 9'd300;
        bus.value_valid = 1'b1;
        repeat (11) @(posedge clk);
        #1 bus.value_valid = 1'b0;
        sb.push_back(model(300, 1'b1));
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL accept_c11: busy=%b, required 1", bus.busy);
        end
        wait_ready(1'b0);
        check_display("v300", 1'b0);
    endtask

    task automatic test_reset_abort();
        bit hit;
        accept(1'b0, 123, 1'b1);
        wait_ready(1'b0);
        check_display("v123", 1'b0);
        accept(1'b0, 456, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.value_ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_fsm: ready=%b busy=%b, required 1/0", bus.value_ready, bus.busy);
        end
        tests++;
        if (an_n !== 4'b1110 || seg_n !== 7'b1000000) begin
            fails++;
            $display("FAIL abort_display: an_n=%b seg_n=%b, required 1110/1000000", an_n, seg_n);
        end
        sb.push_back(model(0, 1'b1));
        check_display("abort", 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) hit = 1'b1;
        end
        tests++;
        if (hit) begin
            fails++;
            $display("FAIL abort_quiet: busy seen high, required 0");
        end
    endtask

    task automatic test_blank_middle();
        accept(1'b0, 100, 1'b1);
        wait_ready(1'b0);
        check_display("v100", 1'b0);
        accept(1'b0, 9, 1'b1);
        wait_ready(1'b0);
        check_display("v9", 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency_255();
        test_range();
        test_back_to_back();
        test_reset_abort();
        test_blank_middle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
